// File: rtl/flip_flop_pkg.sv
// flip_flop_pkg: shared JK conflict-mode type and constants
package flip_flop_pkg;
    typedef logic [1:0] jk_conflict_mode;
    localparam jk_conflict_mode JK_CONFLICT_TOGGLE = 2'd0;
    localparam jk_conflict_mode JK_CONFLICT_SET    = 2'd1;
    localparam jk_conflict_mode JK_CONFLICT_RESET  = 2'd2;
    localparam jk_conflict_mode JK_CONFLICT_HOLD   = 2'd3;
endpackage

// File: rtl/jk_flip_flop_cell.sv
// jk_flip_flop_cell: one JK channel (clear > load > enable > JK) with registered state/rose/fell, async active-low reset to reset_value
module jk_flip_flop_cell
    import flip_flop_pkg::*;
#(
    parameter int CONFLICT_MODE = 0
) (
    input  logic clock,
    input  logic resetn,
    input  logic enable,
    input  logic clear,
    input  logic load,
    input  logic load_value,
    input  logic j,
    input  logic k,
    input  logic reset_value,
    output logic state,
    output logic rose,
    output logic fell
);
    if (CONFLICT_MODE < 0 || CONFLICT_MODE > 3) begin : g_bad_mode
        $error("jk_flip_flop_cell: CONFLICT_MODE %0d out of range 0..3", CONFLICT_MODE);
    end
    localparam jk_conflict_mode MODE = jk_conflict_mode'(CONFLICT_MODE);
    logic conflict_next, jk_next, state_next;
    always_comb begin
        conflict_next = MODE == JK_CONFLICT_TOGGLE ? ~state :
                        MODE == JK_CONFLICT_SET    ? 1'b1   :
                        MODE == JK_CONFLICT_RESET  ? 1'b0   : state;
        jk_next       = j && k ? conflict_next : j ? 1'b1 : k ? 1'b0 : state;
        state_next    = clear ? reset_value : load ? load_value : !enable ? state : jk_next;
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= reset_value;
            rose  <= 1'b0;
            fell  <= 1'b0;
        end else begin
            state <= state_next;
            rose  <= ~state & state_next;
            fell  <= state & ~state_next;
        end
    end
endmodule

// File: rtl/jk_register.sv
// jk_register: WIDTH independent JK flag channels; ports clock, resetn, enable, clear, load, load_value, j, k -> state, rose, fell
module jk_register
    import flip_flop_pkg::*;
#(
    parameter int                WIDTH         = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE   = '0,
    parameter int                CONFLICT_MODE = 0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] rose,
    output logic [WIDTH-1:0] fell
);
    if (WIDTH < 1) begin : g_bad_width
        $error("jk_register: WIDTH must be at least 1");
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_flip_flop_cell #(
            .CONFLICT_MODE(CONFLICT_MODE)
        ) u_cell (
            .clock      (clock),
            .resetn     (resetn),
            .enable     (enable),
            .clear      (clear),
            .load       (load),
            .load_value (load_value[i]),
            .j          (j[i]),
            .k          (k[i]),
            .reset_value(RESET_VALUE[i]),
            .state      (state[i]),
            .rose       (rose[i]),
            .fell       (fell[i])
        );
    end
endmodule

// File: tb/tb_jk_register.sv
// tb_jk_register: four-mode plus WIDTH=1 bench against a per-bit JK rule model
module tb_jk_register;
    localparam logic [3:0] RV = 4'b1010;
    logic clock = 1'b0, run = 1'b0, on = 1'b0;
    logic resetn = 1'b1, enable = 1'b1, clear = 1'b0, load = 1'b0;
    logic [3:0] load_value = '0, j = '0, k = '0;
    logic [3:0] st [5], ro [5], fe [5];
    logic [0:0] st1, ro1, fe1;
    logic [3:0] m_st [5], m_ro [5], m_fe [5];
    int compared = 0, mismatched = 0;
    initial forever begin
        #5;
        if (run) clock = ~clock;
    end
    for (genvar g = 0; g < 4; g++) begin : g_dut
        jk_register #(.WIDTH(4), .RESET_VALUE(RV), .CONFLICT_MODE(g)) u_dut (
            .clock(clock), .resetn(resetn), .enable(enable), .clear(clear), .load(load),
            .load_value(load_value), .j(j), .k(k), .state(st[g]), .rose(ro[g]), .fell(fe[g])
        );
    end
    jk_register #(.WIDTH(1), .RESET_VALUE(1'b1), .CONFLICT_MODE(0)) u_w1 (
        .clock(clock), .resetn(resetn), .enable(enable), .clear(clear), .load(load),
        .load_value(load_value[0:0]), .j(j[0:0]), .k(k[0:0]), .state(st1), .rose(ro1), .fell(fe1)
    );
    assign st[4] = {3'b000, st1};
    assign ro[4] = {3'b000, ro1};
    assign fe[4] = {3'b000, fe1};
    function automatic int mode_of(int n);
        return n == 4 ? 0 : n;
    endfunction
    function automatic logic [3:0] rv_of(int n);
        return n == 4 ? 4'b0001 : RV;
    endfunction
    function automatic logic [3:0] mask_of(int n);
        return n == 4 ? 4'b0001 : 4'b1111;
    endfunction
    function automatic logic [3:0] model_next(int n, logic [3:0] s);
        logic [3:0] r;
        if (clear) return rv_of(n);
        if (load) return load_value & mask_of(n);
        if (!enable) return s;
        r = s;
        for (int b = 0; b < 4; b++) begin
            if (j[b] && !k[b]) r[b] = 1'b1;
            else if (!j[b] && k[b]) r[b] = 1'b0;
            else if (j[b] && k[b]) begin
                if (mode_of(n) == 0) r[b] = !s[b];
                else if (mode_of(n) == 1) r[b] = 1'b1;
                else if (mode_of(n) == 2) r[b] = 1'b0;
            end
        end
        return r & mask_of(n);
    endfunction
    always @(posedge clock or negedge resetn) begin
        for (int n = 0; n < 5; n++) begin
            if (!resetn) begin
                m_st[n] <= rv_of(n);
                m_ro[n] <= '0;
                m_fe[n] <= '0;
            end else begin
                m_st[n] <= model_next(n, m_st[n]);
                m_ro[n] <= model_next(n, m_st[n]) & ~m_st[n];
                m_fe[n] <= m_st[n] & ~model_next(n, m_st[n]);
            end
        end
    end
    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clock) begin
        if (on) begin
            for (int n = 0; n < 5; n++) begin
                chk($sformatf("model state m%0d", n), st[n], m_st[n]);
                chk($sformatf("model rose m%0d", n), ro[n], m_ro[n]);
                chk($sformatf("model fell m%0d", n), fe[n], m_fe[n]);
            end
        end
    end
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask
    task automatic lit(input string name, input int n, input logic [3:0] s, input logic [3:0] r, input logic [3:0] f);
        chk({name, " state"}, st[n], s);
        chk({name, " rose"}, ro[n], r);
        chk({name, " fell"}, fe[n], f);
    endtask
    initial begin
        #3 resetn = 1'b0;
        #1;
        for (int n = 0; n < 4; n++) lit("reset stopped clock", n, RV, 4'b0000, 4'b0000);
        lit("reset width1", 4, 4'b0001, 4'b0000, 4'b0000);
        resetn = 1'b1;
        on = 1'b1;
        run = 1'b1;
        load = 1'b1; load_value = 4'b0000;
        tick();
        lit("load zero", 0, 4'b0000, 4'b0000, 4'b1010);
        load = 1'b0; j = 4'b0011; k = 4'b1000;
        tick();
        lit("basic jk", 0, 4'b0011, 4'b0011, 4'b0000);
        j = 4'b0000; k = 4'b0000;
        tick();
        lit("basic hold", 0, 4'b0011, 4'b0000, 4'b0000);
        load = 1'b1; load_value = 4'b0101;
        tick();
        load = 1'b0; j = 4'b1111; k = 4'b1111;
        tick();
        lit("conflict toggle", 0, 4'b1010, 4'b1010, 4'b0101);
        lit("conflict set", 1, 4'b1111, 4'b1010, 4'b0000);
        lit("conflict reset", 2, 4'b0000, 4'b0000, 4'b0101);
        lit("conflict hold", 3, 4'b0101, 4'b0000, 4'b0000);
        load = 1'b1; load_value = 4'b0000; k = 4'b0000;
        tick();
        clear = 1'b1; load_value = 4'b1111;
        tick();
        lit("clear over load", 0, RV, 4'b1010, 4'b0000);
        clear = 1'b0;
        tick();
        lit("load after clear", 0, 4'b1111, 4'b0101, 4'b0000);
        load = 1'b0; clear = 1'b1; j = 4'b0000;
        tick();
        lit("clear pulses", 0, RV, 4'b0000, 4'b0101);
        tick();
        lit("clear at reset value", 0, RV, 4'b0000, 4'b0000);
        clear = 1'b0; load = 1'b1; load_value = 4'b0110;
        tick();
        load = 1'b0; enable = 1'b0; j = 4'b1001; k = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            tick();
            lit("enable gated", 0, 4'b0110, 4'b0000, 4'b0000);
        end
        enable = 1'b1;
        tick();
        lit("enable resumes", 0, 4'b1001, 4'b1001, 4'b0110);
        j = 4'b0001; k = 4'b0001;
        for (int c = 0; c < 5; c++) tick();
        lit("toggle run", 0, 4'b1000, 4'b0000, 4'b0001);
        #2 resetn = 1'b0;
        #1;
        lit("reset mid toggle", 0, RV, 4'b0000, 4'b0000);
        lit("reset mid hold mode", 3, RV, 4'b0000, 4'b0000);
        tick();
        resetn = 1'b1;
        tick();
        lit("toggle after reset", 0, 4'b1011, 4'b0001, 4'b0000);
        tick();
        lit("toggle back", 0, RV, 4'b0000, 4'b0001);
        on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/jk_register.md
Name: jk_register

Overview:
- Parametrised bank of WIDTH independent JK flip-flop channels sharing one clock.
- Adds over the single-bit JK flip-flop:
  - async active-low reset to a programmable value;
  - configurable J&K conflict resolution;
  - global enable, synchronous clear and parallel load;
  - registered per-channel rise/fall pulses.
- Used as a status/flag register for interrupt and event latching in peripheral blocks.

Parameters:
- WIDTH, 8, number of JK channels (≥1).
- RESET_VALUE, 0, WIDTH-bit value loaded into state on reset and on clear.
- CONFLICT_MODE, 0, action when j[i]&&k[i]: 0=TOGGLE, 1=SET priority, 2=RESET priority, 3=HOLD.

Ports:
- clock  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- enable  input  1  when low, j/k are ignored and state holds; clear/load still act.
- clear  input  1  synchronous clear of state to RESET_VALUE.
- load  input  1  synchronous parallel load of state from load_value.
- load_value  input  WIDTH  value written on load.
- j  input  WIDTH  per-channel set/J input.
- k  input  WIDTH  per-channel reset/K input.
- state  output  WIDTH  current channel states (registered).
- rose  output  WIDTH  one-cycle pulse: channel went 0→1 on the last edge.
- fell  output  WIDTH  one-cycle pulse: channel went 1→0 on the last edge.

Behaviour:
- Reset (resetn=0, asynchronous, no clock needed):
  - state=RESET_VALUE, rose=0, fell=0.
  - Deassertion is taken synchronously by the integrator; the block needs no internal synchroniser.
  - First edge after release evaluates inputs normally.
  - Reset asserted mid-operation overrides everything immediately.
- Priority per rising edge, highest first, same for all channels:
  1. clear → state_next=RESET_VALUE.
  2. load → state_next=load_value.
  3. enable=0 → state_next=state.
  4. JK rules, per channel i:
     - j=0,k=0 → hold.
     - j=1,k=0 → 1.
     - j=0,k=1 → 0.
     - j=1,k=1 → per CONFLICT_MODE: TOGGLE=~state[i]; SET=1; RESET=0; HOLD=state[i].
- Latency: state updates on the edge where inputs are sampled; no pipeline beyond one register.
- Change pulses:
  - rose[i] and fell[i] are registered on the same edge as state.
  - rose[i]=~state[i]&state_next[i]; fell[i]=state[i]&~state_next[i].
  - Each pulse is high for exactly one cycle, coincident with the first cycle state shows the new value.
  - They clear on the next edge unless another transition occurs.
  - A channel toggling every cycle shows rose and fell alternating, never both high together.
- Clear and load generate rose/fell pulses like any other transition. Clear when state already equals RESET_VALUE → no pulses.
- enable=0 with no clear/load: no transitions, so rose=fell=0 on the next edge.
- Illegal CONFLICT_MODE (>3): elaboration-time error.
- WIDTH=1 must be legal.
- No combinational path from any input to any output.

Decomposition:
- Shared package flip_flop_pkg holds:
  - conflict-mode constants JK_CONFLICT_TOGGLE=0, JK_CONFLICT_SET=1, JK_CONFLICT_RESET=2, JK_CONFLICT_HOLD=3;
  - a 2-bit jk_conflict_mode type.
- One sub-module is natural: jk_flip_flop_cell.
  - Single-channel next-state logic plus state/rose/fell registers, with async active-low reset.
  - Ports: clock, resetn, enable, clear, load, load_value, j, k, reset_value.
  - Parameter: CONFLICT_MODE.
  - jk_register instantiates WIDTH cells in a generate loop.

Test Plan:
- Reset: WIDTH=4, RESET_VALUE=4'b1010, pulse resetn low with clock stopped → state=1010 immediately, rose=fell=0000.
- Basic JK: from state=0000, apply j=0011,k=1000 → next edge: state=0011, rose=0011, fell=0000; following edge with j=k=0 → state=0011, rose=0000.
- Conflict modes: state=0101, j=k=1111 for one edge.
  - TOGGLE → state=1010, rose=1010, fell=0101.
  - SET → 1111.
  - RESET → 0000.
  - HOLD → 0101, no pulses.
- Priority: state=0000, clear=1, load=1, load_value=1111, j=1111, RESET_VALUE=0000 → state=0000, no pulses; then clear=0 → state=1111, rose=1111.
- Enable gating: state=0110, enable=0, j=1001,k=0110 for 3 edges → state stays 0110, rose=fell=0000; enable=1 → state=1001, rose=1001, fell=0110.
- Reset mid-toggle: TOGGLE mode, j=k=0001 toggling for 5 cycles, assert resetn=0 between edges → state=RESET_VALUE asynchronously, pulses cleared; release and verify toggling resumes from RESET_VALUE.
